neopixel_frame_sched: RTL and testbench
=======================================

# neopixel_frame_sched

Frame scheduler that sequences a WS2812 string from a pixel frame buffer. For each frame it fetches NUM_PIXELS 24-bit GRB words, pushes them as color messages into the transmitter's message FIFO, appends one reset message, and gates the transmitter's `tx_enable` so the FIFO is preloaded before transmission starts. Frames are triggered manually or by a programmable refresh timer. It sits between the frame-buffer RAM and the FIFO that feeds the serial transmitter.

## Interface
- NUM_PIXELS, 18, pixels per frame (1..2^ADDR_W)
- ADDR_W, 5, frame-buffer address width
- PRELOAD, 4, FIFO entries written before `tx_enable` rises
- clk  in  1  20 MHz system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle frame request
- auto_en  in  1  enables timer-triggered frames
- period_cycles  in  24  refresh period in clk cycles
- fb_rd  out  1  frame-buffer read strobe
- fb_addr  out  ADDR_W  frame-buffer read address
- fb_data  in  24  read data, valid the cycle after `fb_rd`
- fifo_full  in  1  message FIFO full
- fifo_empty  in  1  message FIFO empty
- fifo_wr  out  1  FIFO write strobe
- fifo_din  out  25  {msg type (1 = color, 0 = reset), 24-bit GRB}
- tx_enable  out  1  transmitter enable
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse when a frame has fully drained
- overrun  out  1  sticky: a trigger arrived while one was already pending

## Operation
- States: IDLE, READ, CAPTURE, PUSH, PUSH_RST, DRAIN.
- IDLE: on trigger (start, pending flag, or timer tick with auto_en), clear index to 0, set busy, clear pending, go to READ.
- READ: `fb_rd` = 1, `fb_addr` = index, go to CAPTURE.
- CAPTURE: register {1'b1, fb_data} into `fifo_din`, go to PUSH.
- PUSH: `fifo_wr` = !fifo_full. On a write, if index = NUM_PIXELS-1 go to PUSH_RST, else increment index and go to READ. While full, hold the state and `fifo_din`.
- PUSH_RST: `fifo_din` = 25'h0. Write when !fifo_full, then go to DRAIN.
- DRAIN: wait for fifo_empty = 1. Then drop `tx_enable` and `busy`, pulse `frame_done`, and go to IDLE.
- `tx_enable` rises on the cycle after the PRELOAD-th write of the frame, or after the reset-message write, whichever comes first. It stays high until DRAIN exits.
- Timer: 24-bit down-counter, loaded with period_cycles-1 and reloaded on each tick; it runs only while auto_en = 1. period_cycles = 0 means a continuous trigger whenever auto_en = 1.
- A trigger (start or tick) while busy sets pending. A trigger while pending is already set also sets `overrun`. Pending frames start immediately on the next IDLE entry.
- `overrun` is cleared only by rst.
- A start and a tick in the same cycle count as a single trigger.

## Timing
- Reset values: fb_rd 0, fb_addr 0, fifo_wr 0, fifo_din 0, tx_enable 0, busy 0, frame_done 0, overrun 0, state IDLE, timer loaded, pending 0.
- All outputs are registered except `fifo_wr`, which is the state decode AND !fifo_full, evaluated the same cycle.
- Trigger-to-first `fb_rd`: 1 cycle (IDLE to READ).
- Each pixel takes 3 cycles with the FIFO not full, so a frame queues in 3·NUM_PIXELS+1 cycles (55 for 18 pixels).
- `fb_addr` is held stable from READ through CAPTURE.
- rst mid-frame: immediate return to reset values. FIFO contents are not flushed; clearing them is the FIFO owner's job. `tx_enable` low stops the transmitter at its next FIFO check.

## Test plan
- NUM_PIXELS=18, FIFO never full, fb_data = 24'h010000 + addr, pulse start → 18 writes of {1, 24'h0100nn} for nn = 0..17 at 3-cycle spacing, then 25'h0. `tx_enable` rises after the 4th write. After fifo_empty, `frame_done` pulses once and `tx_enable` and `busy` return to 0.
- Hold fifo_full high for 10 cycles during pixel 5 → `fifo_wr` stays 0 and `fifo_din` is held. Pixel 5 is written on the first cycle with full low; no data is lost or duplicated.
- auto_en=1, period_cycles=200, FIFO drained instantly → a frame starts every 200 cycles and `overrun` stays 0.
- period_cycles=20 with a slow-draining FIFO → the first extra tick sets pending, the second sets `overrun`, and the pending frame starts on the cycle after `frame_done`.
- Assert rst during pixel 9 → all outputs return to reset values asynchronously. After release, start begins a new frame at fb_addr 0.
- NUM_PIXELS=2, PRELOAD=4 → `tx_enable` rises after the reset-message write.

Source files
------------

// File: rtl/neopixel_frame_sched.sv
// Frame scheduler for a WS2812 string: fetches NUM_PIXELS GRB words from the
// frame buffer, queues them plus a reset message, and gates tx_enable.
module neopixel_frame_sched #(
  parameter int NUM_PIXELS = 18,
  parameter int ADDR_W     = 5,
  parameter int PRELOAD    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              auto_en,
  input  logic [23:0]       period_cycles,
  output logic              fb_rd,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [23:0]       fb_data,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  output logic              fifo_wr,
  output logic [24:0]       fifo_din,
  output logic              tx_enable,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, PUSH, PUSH_RST, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] index;
  logic [23:0]       timer;
  logic              timer_armed;
  logic              pending;
  logic              tick;
  logic              trig;
  logic              last_pix;
  logic              preload_hit;

  assign fifo_wr     = ((state == PUSH) || (state == PUSH_RST)) && !fifo_full;
  assign tick        = auto_en && timer_armed && ((period_cycles == 24'd0) || (timer == 24'd0));
  assign trig        = start | tick;
  assign last_pix    = (index == ADDR_W'(NUM_PIXELS - 1));
  // The write in PUSH is pixel number index+1 of the frame.
  assign preload_hit = (32'(index) + 32'd1) >= 32'(PRELOAD);

  // Refresh timer: parked at period-1 while auto_en is low so that enabling
  // it always yields a full first period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer       <= '0;
      timer_armed <= 1'b0;
    end else if (!auto_en || !timer_armed) begin
      timer       <= period_cycles - 24'd1;
      timer_armed <= 1'b1;
    end else if (timer == 24'd0) begin
      timer <= period_cycles - 24'd1;
    end else begin
      timer <= timer - 24'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      index      <= '0;
      fb_rd      <= 1'b0;
      fb_addr    <= '0;
      fifo_din   <= '0;
      tx_enable  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      pending    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      fb_rd      <= 1'b0;
      if (trig && (state != IDLE)) begin
        pending <= 1'b1;
        if (pending) overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (trig || pending) begin
            index   <= '0;
            fb_addr <= '0;
            fb_rd   <= 1'b1;
            busy    <= 1'b1;
            pending <= 1'b0;
            state   <= READ;
          end
        end
        READ: state <= CAPTURE;
        CAPTURE: begin
          fifo_din <= {1'b1, fb_data};
          state    <= PUSH;
        end
        PUSH: begin
          if (!fifo_full) begin
            if (preload_hit) tx_enable <= 1'b1;
            if (last_pix) begin
              fifo_din <= '0;
              state    <= PUSH_RST;
            end else begin
              index   <= index + 1'b1;
              fb_addr <= index + 1'b1;
              fb_rd   <= 1'b1;
              state   <= READ;
            end
          end
        end
        PUSH_RST: begin
          if (!fifo_full) begin
            tx_enable <= 1'b1;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            tx_enable  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_frame_sched.sv
// Bench for neopixel_frame_sched: frame-buffer/FIFO environment, write
// scoreboard and timing expectations derived from the frame sequencing rules.
module tb_neopixel_frame_sched;
  localparam int NP = 18;
  localparam int AW = 5;
  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          rst, start, auto_en, fifo_full, fifo_empty, start2;
  logic [23:0]   period_cycles, fb_data, fb_data2;
  logic          fb_rd, fifo_wr, tx_enable, busy, frame_done, overrun;
  logic [AW-1:0] fb_addr, fb_addr2;
  logic [24:0]   fifo_din, fifo_din2;
  logic          fb_rd2, fifo_wr2, tx2, busy2, done2, ovr2;

  neopixel_frame_sched #(.NUM_PIXELS(NP), .ADDR_W(AW), .PRELOAD(PL)) dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en),
    .period_cycles(period_cycles), .fb_rd(fb_rd), .fb_addr(fb_addr),
    .fb_data(fb_data), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_wr(fifo_wr), .fifo_din(fifo_din), .tx_enable(tx_enable),
    .busy(busy), .frame_done(frame_done), .overrun(overrun));

  neopixel_frame_sched #(.NUM_PIXELS(2), .ADDR_W(AW), .PRELOAD(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .auto_en(1'b0),
    .period_cycles(period_cycles), .fb_rd(fb_rd2), .fb_addr(fb_addr2),
    .fb_data(fb_data2), .fifo_full(1'b0), .fifo_empty(1'b1),
    .fifo_wr(fifo_wr2), .fifo_din(fifo_din2), .tx_enable(tx2),
    .busy(busy2), .frame_done(done2), .overrun(ovr2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [24:0] d; } wr_t;
  wr_t  wr_q[$];
  int   start_q[$];
  int   rd_q[$];
  int   tx_rise = -1, done_cnt = 0, done_cyc = -1;
  logic done_busy, done_tx;
  logic prev_rd = 1'b0, prev_tx = 1'b0, prev_done = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [23:0] mem  [32];
  logic [23:0] mem2 [32];
  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Frame-buffer RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (fb_rd)  fb_data  <= mem[fb_addr];
    if (fb_rd2) fb_data2 <= mem2[fb_addr2];
  end

  always @(negedge clk) begin
    if (fifo_wr) begin
      wr_q.push_back('{c: cyc, d: fifo_din});
      chk("wr_while_full", 32'(fifo_full), 0);
    end
    if (fb_rd) begin
      rd_q.push_back(int'(fb_addr));
      if (fb_addr == '0) start_q.push_back(cyc);
    end
    if (prev_rd && !rst) chk("addr_hold", 32'(fb_addr), 32'(prev_addr));
    if (tx_enable && !prev_tx) tx_rise = cyc;
    if (frame_done) begin
      chk("done_width", 32'(prev_done), 0);
      done_cnt++;
      done_cyc  = cyc;
      done_busy = busy;
      done_tx   = tx_enable;
    end
    prev_rd   = fb_rd;
    prev_addr = fb_addr;
    prev_tx   = tx_enable;
    prev_done = frame_done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int e);
    wr_q.delete(); rd_q.delete(); start_q.delete();
    tx_rise = -1;
    start = 1'b1;
    e = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_writes(input int n, input bit rnd);
    int t = 0;
    while (wr_q.size() < n && t < 2000) begin
      if (rnd) fifo_full = ($urandom_range(0, 2) == 0);
      step();
      t++;
    end
    fifo_full = 1'b0;
    if (wr_q.size() < n) chk("wr_timeout", wr_q.size(), n);
  endtask

  task automatic wait_done(input int prev);
    int t = 0;
    while (done_cnt == prev && t < 500) begin
      step();
      t++;
    end
    chk("done_seen", done_cnt, prev + 1);
  endtask

  task automatic check_frame(input int e, input bit exact);
    chk("rd_first", (start_q.size() > 0) ? start_q[0] : -1, e);
    chk("rd_count", rd_q.size(), NP);
    for (int k = 0; k < NP && k < rd_q.size(); k++) chk("rd_seq", rd_q[k], k);
    chk("wr_count", wr_q.size(), NP + 1);
    if (wr_q.size() == NP + 1) begin
      for (int k = 0; k < NP; k++) begin
        chk("pix_data", 32'(wr_q[k].d), 32'({1'b1, mem[k]}));
        if (exact) chk("pix_cycle", wr_q[k].c, e + 2 + 3 * k);
      end
      chk("rst_msg", 32'(wr_q[NP].d), 0);
      if (exact) chk("rst_cycle", wr_q[NP].c, e + 3 * NP);
      chk("tx_rise", tx_rise, wr_q[PL-1].c + 1);
    end
  endtask

  task automatic run_auto(input int p);
    int a, t;
    period_cycles = 24'(p);
    step();
    start_q.delete();
    auto_en = 1'b1;
    a = cyc + 1;
    t = 0;
    while (start_q.size() < 4 && t < 5 * p + 100) begin
      step();
      t++;
    end
    auto_en = 1'b0;
    chk("auto_starts", start_q.size(), 4);
    chk("auto_first", (start_q.size() > 0) ? start_q[0] : -1, a + p - 1);
    for (int i = 0; i + 1 < start_q.size(); i++) chk("auto_period", start_q[i+1] - start_q[i], p);
    chk("auto_no_overrun", 32'(overrun), 0);
    repeat (80) step();
  endtask

  task automatic reset_dut();
    rst = 1'b1; start = 1'b0; start2 = 1'b0; auto_en = 1'b0;
    fifo_full = 1'b0; fifo_empty = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int e, w, d, a, e2, tx2r;
    int w2c[$];
    logic [24:0] w2d[$];
    logic ptx2;

    period_cycles = 24'd200;
    for (int i = 0; i < 32; i++) begin
      mem[i]  = 24'h010000 + 24'(i);
      mem2[i] = 24'($urandom);
    end

    // Reset values
    rst = 1'b1; start = 1'b0; start2 = 1'b0; auto_en = 1'b0;
    fifo_full = 1'b0; fifo_empty = 1'b1;
    repeat (3) step();
    chk("rst_fb_rd", 32'(fb_rd), 0);
    chk("rst_fb_addr", 32'(fb_addr), 0);
    chk("rst_fifo_wr", 32'(fifo_wr), 0);
    chk("rst_fifo_din", 32'(fifo_din), 0);
    chk("rst_tx", 32'(tx_enable), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    step();

    // Directed frame with slow drain
    fifo_empty = 1'b0;
    d = done_cnt;
    pulse_start(e);
    wait_writes(NP + 1, 1'b0);
    check_frame(e, 1'b1);
    chk("drain_busy", 32'(busy), 1);
    chk("drain_tx", 32'(tx_enable), 1);
    repeat (5) step();
    chk("drain_waits", done_cnt, d);
    fifo_empty = 1'b1;
    wait_done(d);
    chk("done_busy_low", 32'(done_busy), 0);
    chk("done_tx_low", 32'(done_tx), 0);
    repeat (5) step();
    chk("done_once", done_cnt, d + 1);

    // Full stall for 10 cycles during pixel 5
    for (int i = 0; i < 32; i++) mem[i] = 24'($urandom);
    d = done_cnt;
    pulse_start(e);
    wait_writes(5, 1'b0);
    w = wr_q[4].c;
    fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_no_wr", 32'(fifo_wr), 0);
      if (cyc >= w + 3) chk("stall_din_held", 32'(fifo_din), 32'({1'b1, mem[5]}));
      step();
    end
    fifo_full = 1'b0;
    wait_writes(NP + 1, 1'b0);
    check_frame(e, 1'b0);
    chk("stall_release", (wr_q.size() > 5) ? wr_q[5].c : -1, w + 11);
    wait_done(d);

    // Random contents with random FIFO back-pressure
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 32; i++) mem[i] = 24'($urandom);
      d = done_cnt;
      pulse_start(e);
      wait_writes(NP + 1, 1'b1);
      check_frame(e, 1'b0);
      wait_done(d);
    end

    // Timer-triggered frames
    run_auto(200);
    run_auto(int'($urandom_range(70, 150)));

    // Pending and overrun with a slow drain
    reset_dut();
    chk("ovr_clear", 32'(overrun), 0);
    fifo_empty = 1'b0;
    period_cycles = 24'd20;
    step();
    start_q.delete(); wr_q.delete(); rd_q.delete();
    auto_en = 1'b1;
    a = cyc + 1;
    while (cyc < a + 58) step();
    chk("ovr_after_pending", 32'(overrun), 0);
    step();
    chk("ovr_set", 32'(overrun), 1);
    auto_en = 1'b0;
    chk("ovr_first_start", (start_q.size() > 0) ? start_q[0] : -1, a + 19);
    wait_writes(NP + 1, 1'b0);
    d = done_cnt;
    fifo_empty = 1'b1;
    wait_done(d);
    step(); step();
    chk("pend_start", (start_q.size() > 1) ? start_q[1] : -1, done_cyc + 1);
    wait_done(d + 1);
    repeat (3) step();
    chk("ovr_sticky", 32'(overrun), 1);

    // Asynchronous reset during pixel 9
    d = done_cnt;
    pulse_start(e);
    wait_writes(9, 1'b0);
    chk("pre_rst_rd", 32'(fb_rd), 1);
    chk("pre_rst_addr", 32'(fb_addr), 9);
    chk("pre_rst_tx", 32'(tx_enable), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_fb_rd", 32'(fb_rd), 0);
    chk("arst_fb_addr", 32'(fb_addr), 0);
    chk("arst_fifo_wr", 32'(fifo_wr), 0);
    chk("arst_fifo_din", 32'(fifo_din), 0);
    chk("arst_tx", 32'(tx_enable), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(frame_done), 0);
    chk("arst_overrun", 32'(overrun), 0);
    step(); step();
    rst = 1'b0;
    step();
    d = done_cnt;
    pulse_start(e);
    wait_writes(NP + 1, 1'b0);
    check_frame(e, 1'b1);
    wait_done(d);

    // Short string: reset message arrives before PRELOAD writes
    tx2r = -1;
    ptx2 = 1'b0;
    start2 = 1'b1;
    e2 = cyc + 1;
    step();
    start2 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (fifo_wr2) begin
        w2c.push_back(cyc);
        w2d.push_back(fifo_din2);
      end
      if (tx2 && !ptx2) tx2r = cyc;
      ptx2 = tx2;
      step();
    end
    chk("short_wr_count", w2c.size(), 3);
    if (w2c.size() == 3) begin
      chk("short_pix0", 32'(w2d[0]), 32'({1'b1, mem2[0]}));
      chk("short_pix1", 32'(w2d[1]), 32'({1'b1, mem2[1]}));
      chk("short_rst_msg", 32'(w2d[2]), 0);
      chk("short_rst_cycle", w2c[2], e2 + 6);
      chk("short_tx_rise", tx2r, w2c[2] + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
